// File: rtl/int_ctrl_pkg.sv
// Shared types and default sizing for the two-source interrupt controller.
package int_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERV1 = 2'd1,
    SERV2 = 2'd2
  } state_t;

  localparam int CNT_W_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/sync_edge.sv
// Synchronizes one asynchronous request line and flags its rising edge.
// Latency SYNC_STAGES cycles to a one-cycle rise pulse; no backpressure, raw is free-running.
module sync_edge
  import int_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/int_ctrl.sv
// Two-source prioritized interrupt controller: latch edges, drive intr1/intr2 until CPU ack.
// Edge to intr in SYNC_STAGES+2 cycles; no backpressure, edges arriving while pending are counted as lost.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       irq_raw,
  input  logic [1:0]       mask,
  input  logic             ack,
  input  logic             clear_lost,
  output logic             intr1,
  output logic             intr2,
  output logic [1:0]       pending,
  output logic [CNT_W-1:0] lost1,
  output logic [CNT_W-1:0] lost2,
  output logic             busy
);

  logic [1:0]       rise;
  logic [1:0]       clr;
  logic [CNT_W-1:0] lost_q [2];
  state_t           state_q, state_d;

  for (genvar i = 0; i < 2; i++) begin : g_src
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .reset(reset),
      .raw  (irq_raw[i]),
      .rise (rise[i])
    );
  end

  assign clr[0] = ack && (state_q == SERV1);
  assign clr[1] = ack && (state_q == SERV2);

  // A new edge wins over a same-cycle ack so the fresh request is never lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      for (int i = 0; i < 2; i++) lost_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (rise[i])
          pending[i] <= 1'b1;
        else if (clr[i])
          pending[i] <= 1'b0;

        if (clear_lost)
          lost_q[i] <= '0;
        else if (rise[i] && pending[i] && !clr[i] && (lost_q[i] != '1))
          lost_q[i] <= lost_q[i] + 1'b1;
      end
    end
  end

  assign lost1 = lost_q[0];
  assign lost2 = lost_q[1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pending[0] && mask[0])
          state_d = SERV1;
        else if (pending[1] && mask[1])
          state_d = SERV2;
      end
      SERV1:   if (ack) state_d = IDLE;
      SERV2:   if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change with the state itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      intr1   <= 1'b0;
      intr2   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      intr1   <= (state_d == SERV1);
      intr2   <= (state_d == SERV2);
      busy    <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: latency, priority, masking, lost-count saturation, ack/edge race, reset.
module tb_int_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] irq_raw;
  logic [1:0] mask;
  logic       ack;
  logic       clear_lost;
  logic       intr1, intr2, busy;
  logic [1:0] pending;
  logic [3:0] lost1, lost2;

  int errors = 0;
  int checks = 0;

  int_ctrl #(.CNT_W(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_raw   (irq_raw),
    .mask      (mask),
    .ack       (ack),
    .clear_lost(clear_lost),
    .intr1     (intr1),
    .intr2     (intr2),
    .pending   (pending),
    .lost1     (lost1),
    .lost2     (lost2),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse2();
    irq_raw = 2'b10;
    step(2);
    irq_raw = 2'b00;
    step(2);
  endtask

  initial begin
    reset = 1'b1; irq_raw = 2'b00; mask = 2'b00; ack = 1'b0; clear_lost = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_intr1", intr1, 0);
    chk("rst_intr2", intr2, 0);
    chk("rst_pending", pending, 0);
    chk("rst_lost1", lost1, 0);
    chk("rst_lost2", lost2, 0);
    chk("rst_busy", busy, 0);
    step(2);
    reset = 1'b1;

    // Basic latency on source 1
    mask = 2'b11;
    irq_raw = 2'b01;
    step(1);
    step(1);
    chk("lat_pend_e1", pending, 2'b00);
    step(1);
    chk("lat_pend_e2", pending, 2'b01);
    chk("lat_intr1_e2", intr1, 0);
    step(1);
    chk("lat_intr1_e3", intr1, 1);
    chk("lat_busy_e3", busy, 1);
    irq_raw = 2'b00;
    ack = 1'b1; step(1); ack = 1'b0;
    chk("ack1_intr1", intr1, 0);
    chk("ack1_pending", pending, 2'b00);
    chk("ack1_busy", busy, 0);
    step(4);

    // Both sources together: priority then forced IDLE gap
    irq_raw = 2'b11;
    step(3);
    chk("both_pending", pending, 2'b11);
    step(1);
    chk("both_intr1", intr1, 1);
    chk("both_intr2_low", intr2, 0);
    irq_raw = 2'b00;
    ack = 1'b1; step(1); ack = 1'b0;
    chk("gap_intr1", intr1, 0);
    chk("gap_intr2", intr2, 0);
    chk("gap_busy", busy, 0);
    chk("gap_pending", pending, 2'b10);
    step(1);
    chk("serv2_intr2", intr2, 1);
    chk("serv2_intr1", intr1, 0);
    ack = 1'b1; step(1); ack = 1'b0;
    chk("serv2_done_busy", busy, 0);
    chk("serv2_done_pend", pending, 2'b00);
    step(4);

    // Masked source 1, ack in IDLE ignored, then unmask
    mask = 2'b10;
    irq_raw = 2'b01;
    step(3);
    irq_raw = 2'b00;
    chk("mask_pending", pending, 2'b01);
    step(3);
    chk("mask_intr1_low", intr1, 0);
    ack = 1'b1; step(1); ack = 1'b0;
    chk("idle_ack_pend", pending, 2'b01);
    mask = 2'b11;
    step(1);
    chk("unmask_intr1", intr1, 1);
    mask = 2'b00;
    step(1);
    chk("mask_in_serv", intr1, 1);
    ack = 1'b1; step(1); ack = 1'b0;
    step(3);

    // Lost-count saturation on source 2
    mask = 2'b00;
    pulse2();
    chk("lost_first_pend", pending, 2'b10);
    chk("lost_first_cnt", lost2, 0);
    for (int p = 0; p < 14; p++) pulse2();
    chk("lost_14", lost2, 14);
    for (int p = 0; p < 4; p++) pulse2();
    chk("lost_sat", lost2, 15);
    chk("lost1_zero", lost1, 0);
    clear_lost = 1'b1; step(1); clear_lost = 1'b0;
    chk("lost_clear", lost2, 0);
    chk("lost_clear_pend", pending, 2'b10);
    mask = 2'b11;
    step(1);
    chk("lost_serv2", intr2, 1);
    ack = 1'b1; step(1); ack = 1'b0;
    chk("lost_ack_pend", pending, 2'b00);
    step(3);

    // Edge coincident with ack in SERV1
    irq_raw = 2'b01;
    step(4);
    chk("race_serv1", intr1, 1);
    irq_raw = 2'b00;
    step(4);
    irq_raw = 2'b01;
    step(2);
    ack = 1'b1; step(1); ack = 1'b0;
    chk("race_pend", pending, 2'b01);
    chk("race_lost1", lost1, 0);
    chk("race_intr1_low", intr1, 0);
    step(1);
    chk("race_intr1_again", intr1, 1);
    irq_raw = 2'b00;
    ack = 1'b1; step(1); ack = 1'b0;
    step(4);

    // Reset during SERV2 with raw held high through release
    mask = 2'b10;
    irq_raw = 2'b10;
    step(4);
    chk("rst_serv2_in", intr2, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_intr2", intr2, 0);
    chk("arst_pending", pending, 2'b00);
    chk("arst_busy", busy, 0);
    step(2);
    reset = 1'b1;
    step(3);
    chk("rel_pending", pending, 2'b10);
    step(1);
    chk("rel_intr2", intr2, 1);
    step(3);
    chk("rel_lost2", lost2, 0);
    ack = 1'b1; step(1); ack = 1'b0;
    step(4);
    chk("rel_single_edge", pending, 2'b00);
    chk("rel_idle_intr2", intr2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
